// File: rtl/alu_seq_responder.sv
// alu_seq_responder: handshaked responder for the W-bit ALU operation set.
// One request in flight at a time; add/cmp/shift finish on the accept edge,
// multiply runs an iterative unsigned shift-add over W cycles.
module alu_seq_responder #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [1:0]     req_sel,
    input  logic [W-1:0]   req_a,
    input  logic [W-1:0]   req_b,
    input  logic           req_cin,
    input  logic           req_op,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [2*W-1:0] rsp_data,
    output logic           rsp_flag,
    output logic [1:0]     rsp_sel,
    output logic [15:0]    op_count
);

    localparam int SW = $clog2(W);
    localparam logic [SW-1:0] LAST_ITER = SW'(W - 1);

    localparam logic [1:0] SEL_ADD = 2'b00;
    localparam logic [1:0] SEL_MUL = 2'b01;
    localparam logic [1:0] SEL_CMP = 2'b10;
    localparam logic [1:0] SEL_SHF = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_RESP
    } state_t;

    state_t state, state_next;

    logic [W-1:0]   mcand;   // multiplicand captured at accept
    logic [2*W-1:0] acc;     // {high partial sum, remaining multiplier bits}
    logic [SW-1:0]  iter;
    logic           accept;

    logic [W:0]     add_sum;
    logic [W-1:0]   shift_res;
    logic [2*W-1:0] imm_data;
    logic           imm_flag;
    logic [W:0]     hi_sum;
    logic [2*W-1:0] acc_next;

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state and handshake outputs
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned
        // (which would infer a latch).
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                // Held low while reset is asserted so nothing is accepted then.
                req_ready = rst_n;
                if (req_valid && rst_n)
                    state_next = (req_sel == SEL_MUL) ? S_MUL : S_RESP;
            end
            S_MUL: begin
                if (iter == LAST_ITER) state_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign accept = req_valid && req_ready;

    // Single-cycle operations, evaluated from the request being accepted
    always_comb begin
        add_sum   = {1'b0, req_a} + {1'b0, req_b} + {{W{1'b0}}, req_cin};
        shift_res = req_op ? (req_a << req_b[SW-1:0]) : (req_a >> req_b[SW-1:0]);
        imm_data  = '0;
        imm_flag  = 1'b0;
        case (req_sel)
            SEL_ADD: begin
                imm_data = {{W{1'b0}}, add_sum[W-1:0]};
                imm_flag = add_sum[W];
            end
            SEL_CMP: begin
                imm_data[2:0] = {req_a > req_b, req_a < req_b, req_a == req_b};
                imm_flag      = (req_a == req_b);
            end
            SEL_SHF: begin
                imm_data = {{W{1'b0}}, shift_res};
                imm_flag = (shift_res == '0);
            end
            default: begin
                imm_data = '0;
                imm_flag = 1'b0;
            end
        endcase
    end

    // One shift-add step: conditionally add multiplicand into the high half,
    // then shift the whole accumulator (with the carry) right by one.
    always_comb begin
        hi_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mcand} : {(W+1){1'b0}});
        acc_next = {hi_sum, acc[W-1:1]};
    end

    // Request capture, multiply iteration, response registers and op counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_count <= '0;
            rsp_data <= '0;
            rsp_flag <= 1'b0;
            rsp_sel  <= '0;
            mcand    <= '0;
            acc      <= '0;
            iter     <= '0;
        end else begin
            if (accept) begin
                op_count <= op_count + 16'd1;
                rsp_sel  <= req_sel;
                mcand    <= req_a;
                acc      <= {{W{1'b0}}, req_b};
                iter     <= '0;
                if (req_sel != SEL_MUL) begin
                    rsp_data <= imm_data;
                    rsp_flag <= imm_flag;
                end
            end
            if (state == S_MUL) begin
                acc  <= acc_next;
                iter <= iter + 1'b1;
                if (iter == LAST_ITER) begin
                    rsp_data <= acc_next;
                    rsp_flag <= (acc_next == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_responder.sv
// Directed bench for alu_seq_responder: the driver pushes hand-computed
// expectations into a scoreboard, a negedge monitor pops and compares them.
module tb_alu_seq_responder;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           req_valid;
    logic           req_ready;
    logic [1:0]     req_sel;
    logic [W-1:0]   req_a;
    logic [W-1:0]   req_b;
    logic           req_cin;
    logic           req_op;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [2*W-1:0] rsp_data;
    logic           rsp_flag;
    logic [1:0]     rsp_sel;
    logic [15:0]    op_count;

    alu_seq_responder #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sel   (req_sel),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_flag  (rsp_flag),
        .rsp_sel   (rsp_sel),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] data;
        logic           flag;
        logic [1:0]     sel;
        int             lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   mark   = 0;
    bit   valid_d = 1'b0;
    logic [15:0] exp_count = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: latency on the rising edge of rsp_valid, content on handshake
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            valid_d = 1'b0;
        end else begin
            if (rsp_valid && !valid_d) begin
                if (sb.size() == 0) check("spurious_rsp", 64'(rsp_valid), 64'd0);
                else                check("latency", 64'(cyc - mark + 1), 64'(sb[0].lat));
            end
            if (rsp_valid && rsp_ready && sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_data", 64'(rsp_data), 64'(e.data));
                check("rsp_flag", 64'(rsp_flag), 64'(e.flag));
                check("rsp_sel",  64'(rsp_sel),  64'(e.sel));
            end
            valid_d = rsp_valid;
            if (req_valid && req_ready) mark = cyc + 1;
        end
    end

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            check("rsp_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    // Issue one request; returns #1 after the accept edge.
    task automatic send(input logic [1:0] sel, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic op, input logic [31:0] ed,
                        input logic ef, input int lat, input bit drain);
        int t = 0;
        exp_t e;
        @(posedge clk); #1;
        e.data = ed; e.flag = ef; e.sel = sel; e.lat = lat;
        sb.push_back(e);
        req_sel = sel; req_a = a; req_b = b; req_cin = cin; req_op = op;
        req_valid = 1'b1;
        while (!req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            check("accept_timeout", 64'(req_ready), 64'd1);
            void'(sb.pop_back());
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        exp_count++;
        req_valid = 1'b0;
        // Scramble inputs; the in-flight result must not change.
        req_a = ~a; req_b = ~b; req_cin = ~cin; req_op = ~op; req_sel = ~sel;
        if (drain) wait_drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        req_sel = '0; req_a = '0; req_b = '0; req_cin = 1'b0; req_op = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", 64'(req_ready), 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_data",  64'(rsp_data),  64'd0);
        check("reset_rsp_flag",  64'(rsp_flag),  64'd0);
        check("reset_rsp_sel",   64'(rsp_sel),   64'd0);
        check("reset_op_count",  64'(op_count),  64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_req_ready", 64'(req_ready), 64'd1);

        // add
        send(2'b00, 16'd10,   16'd20,   1'b0, 1'b0, 32'd30,        1'b0, 1,  1'b1);
        send(2'b00, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 32'd0,         1'b1, 1,  1'b1);
        send(2'b00, 16'h1234, 16'h0001, 1'b1, 1'b0, 32'h1236,      1'b0, 1,  1'b1);
        // mul
        send(2'b01, 16'd25,   16'd11,   1'b0, 1'b0, 32'd275,       1'b0, 17, 1'b1);
        send(2'b01, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 32'hFFFE0001,  1'b0, 17, 1'b1);
        send(2'b01, 16'd0,    16'h1234, 1'b0, 1'b0, 32'd0,         1'b1, 17, 1'b1);
        // cmp
        send(2'b10, 16'd12,   16'd12,   1'b0, 1'b0, 32'd1,         1'b1, 1,  1'b1);
        send(2'b10, 16'd20,   16'd10,   1'b0, 1'b0, 32'd4,         1'b0, 1,  1'b1);
        send(2'b10, 16'd3,    16'd9,    1'b0, 1'b0, 32'd2,         1'b0, 1,  1'b1);
        // shift (upper bits of b are ignored)
        send(2'b11, 16'hFF12, 16'd3,    1'b0, 1'b1, 32'h0000F890,  1'b0, 1,  1'b1);
        send(2'b11, 16'hFF12, 16'h0013, 1'b0, 1'b0, 32'h00001FE2,  1'b0, 1,  1'b1);
        send(2'b11, 16'h0001, 16'd0,    1'b0, 1'b1, 32'h00000001,  1'b0, 1,  1'b1);
        send(2'b11, 16'h0001, 16'd15,   1'b0, 1'b1, 32'h00008000,  1'b0, 1,  1'b1);
        send(2'b11, 16'h8000, 16'd15,   1'b0, 1'b0, 32'h00000001,  1'b0, 1,  1'b1);
        send(2'b11, 16'h0001, 16'd1,    1'b0, 1'b0, 32'h00000000,  1'b1, 1,  1'b1);
        @(negedge clk);
        check("op_count_after_ops", 64'(op_count), 64'(exp_count));

        // Backpressure with a second request held on the input
        begin
            exp_t e;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            e.data = 32'd11; e.flag = 1'b0; e.sel = 2'b00; e.lat = 1;
            sb.push_back(e);
            req_sel = 2'b00; req_a = 16'd5; req_b = 16'd6; req_cin = 1'b0; req_valid = 1'b1;
            @(posedge clk); #1;
            exp_count++;
            req_a = 16'd7; req_b = 16'd8;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                check("stall_rsp_valid", 64'(rsp_valid), 64'd1);
                check("stall_rsp_data",  64'(rsp_data),  64'd11);
                check("stall_rsp_flag",  64'(rsp_flag),  64'd0);
                check("stall_rsp_sel",   64'(rsp_sel),   64'd0);
                check("stall_req_ready", 64'(req_ready), 64'd0);
                check("stall_op_count",  64'(op_count),  64'(exp_count));
            end
            @(posedge clk); #1;
            e.data = 32'd15;
            sb.push_back(e);
            rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("post_hs_req_ready", 64'(req_ready), 64'd1);
            check("post_hs_rsp_valid", 64'(rsp_valid), 64'd0);
            @(posedge clk); #1;
            exp_count++;
            req_valid = 1'b0;
            @(negedge clk);
            check("post_hs_op_count", 64'(op_count), 64'(exp_count));
            wait_drain();
        end

        // Reset in the middle of a multiply: no response may ever appear
        send(2'b01, 16'd25, 16'd11, 1'b0, 1'b0, 32'd275, 1'b0, 17, 1'b0);
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        sb.delete();
        exp_count = '0;
        @(posedge clk);
        @(negedge clk);
        check("midreset_req_ready", 64'(req_ready), 64'd0);
        check("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("release_rsp_valid", 64'(rsp_valid), 64'd0);
        check("release_op_count",  64'(op_count),  64'd0);
        check("release_req_ready", 64'(req_ready), 64'd1);
        repeat (25) @(negedge clk);
        send(2'b00, 16'd10, 16'd20, 1'b0, 1'b0, 32'd30, 1'b0, 1, 1'b1);
        @(negedge clk);
        check("final_op_count", 64'(op_count), 64'(exp_count));

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
